conv1d_mac_sequencer: RTL and testbench
=======================================

Name: conv1d_mac_sequencer

Overview:
- Initiator-side controller for the 14x14 saturating MAC (pipelined multiplier, 28b pipeline register, 28b saturating accumulator).
- Loads M weights and N input samples over a valid/ready stream and stores them in internal register arrays.
- Sequences the MAC through every valid-mode 1D convolution window, driving all MAC enables and clears with the correct latency alignment.
- Returns each window result on a valid/ready output stream.

Parameters:
- N, 16, number of input samples (N >= M).
- M, 8, number of weights (taps, >= 1).
- MULT_LAT, 1, cycles from MAC a/b to multiplier output (2-stage multiplier = 1).
- RELU, 0, 1 = clamp negative results to 0 on m_data.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low: 0 = reset.
- s_valid  in  1  load data valid.
- s_ready  out  1  sequencer accepts load data.
- s_data  in  14  signed weight/sample.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_data  out  28  signed window result.
- mac_a  out  14  sample x[k+j] to MAC a.
- mac_b  out  14  weight w[j] to MAC b.
- mac_enable_mult  out  1  multiplier enable.
- mac_en_pipeline_reg  out  1  MAC pipeline register enable.
- mac_en_acc  out  1  accumulator enable.
- mac_clear_acc  out  1  synchronous accumulator clear.
- mac_clear_pipeline_mult  out  1  multiplier pipeline clear.
- mac_f  in  28  MAC accumulator output.

Behaviour:
- Reset (reset=0, async): all outputs 0, all counters 0, state LOAD_W, weight and sample arrays not cleared.
- All outputs are registered. s_ready rises on the first clk edge after reset deasserts.
- States: LOAD_W -> LOAD_X -> CLR -> ISSUE -> DRAIN -> OUT -> (CLR | LOAD_W).
- LOAD_W:
  - s_ready=1; each s_valid&s_ready beat writes w[wcnt] and increments wcnt.
  - The M-th beat moves to LOAD_X.
- LOAD_X:
  - Same handshake writing x[0..N-1].
  - On the N-th beat: s_ready=0, k=0, go to CLR.
- s_valid outside the LOAD states is ignored. Bubbles (s_valid=0) are allowed at any point.
- CLR (1 cycle): mac_clear_acc=1, mac_clear_pipeline_mult=1, all enables 0.
- ISSUE (M cycles, j=0..M-1): mac_a=x[k+j], mac_b=w[j], mac_enable_mult=1.
- Enable alignment:
  - mac_en_pipeline_reg is mac_enable_mult delayed by MULT_LAT cycles.
  - mac_en_acc is mac_enable_mult delayed by MULT_LAT+1 cycles.
  - Use a shift register that keeps running into DRAIN.
- DRAIN (MULT_LAT+2 cycles):
  - mac_enable_mult=0; mac_a/mac_b hold their last values.
  - On the closing edge of the last DRAIN cycle, register mac_f into m_data (RELU=1 and mac_f[27]=1 -> 0), set m_valid=1, go to OUT.
- OUT:
  - m_valid and m_data stay stable until m_ready=1, and no MAC enable is asserted.
  - On handshake: m_valid=0. If k<N-M: k++, go to CLR. Else go to LOAD_W (wcnt=0, s_ready=1).
- Per-window latency: m_valid rises M+MULT_LAT+3 cycles after CLR entry (12 cycles at defaults). Throughput is one result per M+MULT_LAT+4 cycles with m_ready held at 1.
- Windows per load: N-M+1. The address k+j never exceeds N-1.
- Saturation is done by the MAC only; the sequencer passes mac_f through unchanged (except RELU).
- Reset mid-operation:
  - Any state returns to LOAD_W and all MAC controls drop to 0 immediately.
  - A full reload of weights and samples is required. The next CLR removes any stale accumulator or multiplier state.

Test Plan:
- w=all 1, x=1..16, m_ready=1 -> 9 results 36,44,52,...,100 in order. MAC control waveforms are checked cycle-exact against the alignment rules; the first m_valid occurs 12 cycles after CLR.
- w=all -8192, x=all -8192 -> every result 134217727 (0x7FFFFFF), positive saturation.
- w=all 8191, x=all -8192 -> every result -134217728 (0x8000000). Rerun with RELU=1 -> every result 0.
- Hold m_ready=0 for 20 cycles on the 1st result -> m_valid=1 and m_data constant; all mac_* enables 0, s_ready=0. Releasing m_ready gives correct results for the remaining windows.
- Load with random s_valid bubbles, plus s_valid pulses during ISSUE/OUT -> results identical to the first scenario; extra beats are not consumed (s_ready=0).
- Assert reset during ISSUE of k=3 -> all outputs 0 asynchronously; s_ready=1 the first edge after release. Reload with the first scenario's data -> results 36..100 match exactly.

Source files
------------

// File: rtl/conv1d_mac_sequencer_if.sv
// Load and result streams of the conv1d MAC sequencer, grouped as valid/ready channels.
interface conv1d_mac_sequencer_if;
    logic               s_valid;
    logic               s_ready;
    logic signed [13:0] s_data;
    logic               m_valid;
    logic               m_ready;
    logic signed [27:0] m_data;

    modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
    modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data);
endinterface

// File: rtl/conv1d_mac_sequencer.sv
// Loads M weights and N samples, then steps an external 14x14 saturating MAC through
// every valid-mode 1D convolution window and streams out one result per window.
module conv1d_mac_sequencer #(
    parameter int N        = 16,
    parameter int M        = 8,
    parameter int MULT_LAT = 1,
    parameter int RELU     = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    conv1d_mac_sequencer_if.slave  bus,
    output logic signed [13:0]     mac_a,
    output logic signed [13:0]     mac_b,
    output logic                   mac_enable_mult,
    output logic                   mac_en_pipeline_reg,
    output logic                   mac_en_acc,
    output logic                   mac_clear_acc,
    output logic                   mac_clear_pipeline_mult,
    input  logic signed [27:0]     mac_f
);
    localparam int XW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = (M > 1) ? $clog2(M) : 1;
    localparam int DW = $clog2(MULT_LAT + 2);

    typedef enum logic [2:0] {LOAD_W, LOAD_X, CLR, ISSUE, DRAIN, OUT} state_t;

    state_t             state;
    logic signed [13:0] w [M];
    logic signed [13:0] x [N];
    logic [WW-1:0]      wcnt;
    logic [XW-1:0]      xcnt;
    logic [XW-1:0]      k;
    logic [WW-1:0]      j;
    logic [DW-1:0]      dcnt;
    logic [XW-1:0]      next_idx;
    logic [MULT_LAT+1:0] en_sr;
    logic               s_fire;

    assign s_fire   = bus.s_valid && bus.s_ready;
    assign next_idx = k + XW'(j) + XW'(1);

    // Bit 0 is the multiplier enable; later taps line up with the MAC's pipeline stages.
    assign mac_enable_mult     = en_sr[0];
    assign mac_en_pipeline_reg = en_sr[MULT_LAT];
    assign mac_en_acc          = en_sr[MULT_LAT+1];

    // NOTE: operand storage has no reset; every load phase overwrites all of it before use.
    always_ff @(posedge clk) begin
        if (s_fire) begin
            if (state == LOAD_W)      w[wcnt] <= bus.s_data;
            else if (state == LOAD_X) x[xcnt] <= bus.s_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                   <= LOAD_W;
            wcnt                    <= '0;
            xcnt                    <= '0;
            k                       <= '0;
            j                       <= '0;
            dcnt                    <= '0;
            en_sr                   <= '0;
            mac_a                   <= '0;
            mac_b                   <= '0;
            mac_clear_acc           <= 1'b0;
            mac_clear_pipeline_mult <= 1'b0;
            bus.s_ready             <= 1'b0;
            bus.m_valid             <= 1'b0;
            bus.m_data              <= '0;
        end else begin
            en_sr[MULT_LAT+1:1]     <= en_sr[MULT_LAT:0];
            en_sr[0]                <= 1'b0;
            mac_clear_acc           <= 1'b0;
            mac_clear_pipeline_mult <= 1'b0;
            case (state)
                LOAD_W: begin
                    bus.s_ready <= 1'b1;
                    if (s_fire) begin
                        if (wcnt == WW'(M - 1)) begin
                            wcnt  <= '0;
                            xcnt  <= '0;
                            state <= LOAD_X;
                        end else begin
                            wcnt <= wcnt + WW'(1);
                        end
                    end
                end
                LOAD_X: begin
                    if (s_fire) begin
                        if (xcnt == XW'(N - 1)) begin
                            xcnt                    <= '0;
                            k                       <= '0;
                            bus.s_ready             <= 1'b0;
                            mac_clear_acc           <= 1'b1;
                            mac_clear_pipeline_mult <= 1'b1;
                            state                   <= CLR;
                        end else begin
                            xcnt <= xcnt + XW'(1);
                        end
                    end
                end
                CLR: begin
                    j        <= '0;
                    mac_a    <= x[k];
                    mac_b    <= w[0];
                    en_sr[0] <= 1'b1;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    if (j == WW'(M - 1)) begin
                        dcnt  <= '0;
                        state <= DRAIN;
                    end else begin
                        j        <= j + WW'(1);
                        mac_a    <= x[next_idx];
                        mac_b    <= w[j + WW'(1)];
                        en_sr[0] <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (dcnt == DW'(MULT_LAT + 1)) begin
                        bus.m_data  <= ((RELU != 0) && mac_f[27]) ? '0 : mac_f;
                        bus.m_valid <= 1'b1;
                        state       <= OUT;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                OUT: begin
                    if (bus.m_ready) begin
                        bus.m_valid <= 1'b0;
                        if (k < XW'(N - M)) begin
                            k                       <= k + XW'(1);
                            mac_clear_acc           <= 1'b1;
                            mac_clear_pipeline_mult <= 1'b1;
                            state                   <= CLR;
                        end else begin
                            wcnt        <= '0;
                            bus.s_ready <= 1'b1;
                            state       <= LOAD_W;
                        end
                    end
                end
                default: state <= LOAD_W;
            endcase
        end
    end
endmodule

// File: tb/tb_conv1d_mac_sequencer.sv
// Directed bench: two sequencers (RELU=0 and RELU=1) share stimulus, each driving a
// behavioural 14x14 saturating MAC with a registered multiplier stage.
module tb_conv1d_mac_sequencer;
    localparam int N  = 16;
    localparam int M  = 8;
    localparam int ML = 1;

    logic               clk     = 1'b0;
    logic               reset   = 1'b0;
    logic               s_valid = 1'b0;
    logic signed [13:0] s_data  = '0;
    logic               m_ready = 1'b1;

    logic [1:0]         s_ready_o;
    logic [1:0]         m_valid_o;
    logic signed [27:0] m_data_o  [2];
    logic signed [13:0] mac_a_o   [2];
    logic signed [13:0] mac_b_o   [2];
    logic [4:0]         ctl       [2];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        conv1d_mac_sequencer_if bus ();
        logic signed [13:0] mac_a, mac_b;
        logic               en_mult, en_pipe, en_acc, clr_acc, clr_mult;
        logic signed [27:0] prod, pipe, acc;
        logic signed [28:0] sum;

        assign bus.s_valid  = s_valid;
        assign bus.s_data   = s_data;
        assign bus.m_ready  = m_ready;
        assign s_ready_o[g] = bus.s_ready;
        assign m_valid_o[g] = bus.m_valid;
        assign m_data_o[g]  = bus.m_data;
        assign mac_a_o[g]   = mac_a;
        assign mac_b_o[g]   = mac_b;
        assign ctl[g]       = {clr_acc, clr_mult, en_mult, en_pipe, en_acc};

        conv1d_mac_sequencer #(.N(N), .M(M), .MULT_LAT(ML), .RELU(g)) u_dut (
            .clk                     (clk),
            .reset                   (reset),
            .bus                     (bus),
            .mac_a                   (mac_a),
            .mac_b                   (mac_b),
            .mac_enable_mult         (en_mult),
            .mac_en_pipeline_reg     (en_pipe),
            .mac_en_acc              (en_acc),
            .mac_clear_acc           (clr_acc),
            .mac_clear_pipeline_mult (clr_mult),
            .mac_f                   (acc)
        );

        // MAC model is deliberately not reset: a CLR must flush any stale state.
        assign sum = {acc[27], acc} + {pipe[27], pipe};
        always_ff @(posedge clk) begin
            if (clr_mult)     prod <= '0;
            else if (en_mult) prod <= {{14{mac_a[13]}}, mac_a} * {{14{mac_b[13]}}, mac_b};
            if (en_pipe)      pipe <= prod;
            if (clr_acc)      acc  <= '0;
            else if (en_acc)  acc  <= (sum > 29'sd134217727)  ? 28'sh7FFFFFF :
                                      (sum < -29'sd134217728) ? 28'sh8000000 : sum[27:0];
        end
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic send(input logic signed [13:0] v, input int bubbles);
        int cnt = 0;
        s_valid = 1'b0;
        repeat (bubbles) @(negedge clk);
        s_valid = 1'b1;
        s_data  = v;
        while (!s_ready_o[0] && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 100) check("send_timeout", cnt, 0);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic load(input logic signed [13:0] wv, input logic signed [13:0] xv,
                        input bit ramp, input int max_bubble);
        for (int i = 0; i < M; i++) send(wv, $urandom_range(0, max_bubble));
        for (int i = 0; i < N; i++) send(ramp ? 14'(i + 1) : xv, $urandom_range(0, max_bubble));
    endtask

    // Entered on the negedge of a CLR cycle; m_valid is due 12 cycles after CLR entry.
    task automatic get_result(input string tag, input logic signed [27:0] e0,
                              input logic signed [27:0] e1, input bit pulse);
        int cnt = 0;
        while (!m_valid_o[0] && cnt < 200) begin
            if (pulse) begin
                s_valid = cnt[0];
                s_data  = 14'(cnt);
                check({tag, "_busy_s_ready"}, s_ready_o[0], 0);
            end
            @(negedge clk);
            cnt++;
        end
        s_valid = 1'b0;
        check({tag, "_latency"}, cnt, 12);
        check(tag, m_data_o[0], e0);
        check({tag, "_relu"}, m_data_o[1], e1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        // Reset state
        #12;
        check("rst_ctl", ctl[0], 0);
        check("rst_s_ready", s_ready_o[0], 0);
        check("rst_m_valid", m_valid_o[0], 0);
        @(negedge clk);
        reset = 1'b1;
        check("rel_s_ready_low", s_ready_o[0], 0);
        @(negedge clk);
        check("rel_s_ready_high", s_ready_o[0], 1);

        // Ramp data, cycle-exact control waveform on the first window
        load(14'sd1, 14'sd0, 1'b1, 0);
        check("clr_ctl", ctl[0], 5'b11000);
        for (int j = 0; j < M; j++) begin
            @(negedge clk);
            check("issue_ctl", ctl[0], {3'b001, 1'(j >= 1), 1'(j >= 2)});
            check("issue_a", mac_a_o[0], j + 1);
            check("issue_b", mac_b_o[0], 1);
        end
        for (int d = 0; d < ML + 2; d++) begin
            @(negedge clk);
            check("drain_ctl", ctl[0], {3'b000, 1'(d == 0), 1'(d <= 1)});
            check("drain_a_hold", mac_a_o[0], 8);
            check("drain_m_valid", m_valid_o[0], 0);
        end
        @(negedge clk);
        check("out_m_valid", m_valid_o[0], 1);
        check("out_data_k0", m_data_o[0], 36);
        check("out_ctl", ctl[0], 0);
        check("out_s_ready", s_ready_o[0], 0);
        @(negedge clk);
        for (int k = 1; k <= N - M; k++) get_result("ramp", 28'(36 + 8 * k), 28'(36 + 8 * k), 1'b0);
        check("end_s_ready", s_ready_o[0], 1);
        check("end_m_valid", m_valid_o[0], 0);

        // Positive saturation
        load(-14'sd8192, -14'sd8192, 1'b0, 0);
        for (int k = 0; k <= N - M; k++) get_result("sat_pos", 28'sd134217727, 28'sd134217727, 1'b0);

        // Negative saturation; the RELU instance clamps to zero
        load(14'sd8191, -14'sd8192, 1'b0, 0);
        for (int k = 0; k <= N - M; k++) get_result("sat_neg", -28'sd134217728, 28'sd0, 1'b0);

        // Backpressure on the first result, with stray s_valid pulses
        load(14'sd1, 14'sd0, 1'b1, 0);
        m_ready = 1'b0;
        cnt = 0;
        while (!m_valid_o[0] && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("hold_latency", cnt, 12);
        for (int i = 0; i < 20; i++) begin
            check("hold_ctl", {ctl[0], s_ready_o[0], m_valid_o[0]}, 7'b0000001);
            check("hold_data", m_data_o[0], 36);
            s_valid = i[0];
            @(negedge clk);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= N - M; k++) get_result("after_hold", 28'(36 + 8 * k), 28'(36 + 8 * k), 1'b1);

        // Bubbly load; stray beats while windows run
        load(14'sd1, 14'sd0, 1'b1, 3);
        for (int k = 0; k <= N - M; k++) get_result("bubbles", 28'(36 + 8 * k), 28'(36 + 8 * k), 1'b1);

        // Reset during ISSUE of window k=3, then full reload
        load(14'sd1, 14'sd0, 1'b1, 0);
        for (int k = 0; k < 3; k++) get_result("pre_rst", 28'(36 + 8 * k), 28'(36 + 8 * k), 1'b0);
        cnt = 0;
        while (!ctl[0][2] && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_issue_seen", ctl[0][2], 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_ctl", ctl[0], 0);
        check("arst_m_data", m_data_o[0], 0);
        check("arst_mac_a", mac_a_o[0], 0);
        check("arst_mac_b", mac_b_o[0], 0);
        check("arst_flags", {s_ready_o[0], m_valid_o[0]}, 0);
        @(negedge clk);
        reset = 1'b1;
        check("arel_s_ready_low", s_ready_o[0], 0);
        @(negedge clk);
        check("arel_s_ready_high", s_ready_o[0], 1);
        load(14'sd1, 14'sd0, 1'b1, 0);
        for (int k = 0; k <= N - M; k++) get_result("post_rst", 28'(36 + 8 * k), 28'(36 + 8 * k), 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
